// File: rtl/chan_512_start_ctrl_if.sv
// Control/status bundle between the chan_512 start register and the start controller.
// Latency: none, wires only.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface chan_512_start_ctrl_if #(
  parameter int CHAN_BITS = 9
);
  logic [31:0]          reg_in;
  logic                 sync_in;
  logic                 start_out;
  logic                 running;
  logic [CHAN_BITS-1:0] chan_idx;
  logic                 frame_sof;
  logic [31:0]          status_out;

  // Register/software side: drives the control word and sync, observes status.
  modport master (
    output reg_in,
    output sync_in,
    input  start_out,
    input  running,
    input  chan_idx,
    input  frame_sof,
    input  status_out
  );

  // Controller side.
  modport slave (
    input  reg_in,
    input  sync_in,
    output start_out,
    output running,
    output chan_idx,
    output frame_sof,
    output status_out
  );
endinterface

// File: rtl/chan_512_start_ctrl.sv
// Turns the software start/stop word into a timed channelizer start, channel index and frame count.
// Latency: 3 edges from start bit to start_out (plus D delay cycles, or 2 edges from a sync rise when armed).
// Backpressure: none; the channel counter free-runs once started and stops only on a frame boundary.
module chan_512_start_ctrl #(
  parameter int NCHAN      = 512,
  parameter int CHAN_BITS  = 9,
  parameter int DELAY_BITS = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  chan_512_start_ctrl_if.slave ctrl
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_RUN      = 3'd3,
    ST_STOPPING = 3'd4
  } state_t;

  localparam logic [CHAN_BITS-1:0] CHAN_LAST = CHAN_BITS'(NCHAN - 1);

  // Control word pipeline and sync synchroniser stages.
  logic [31:0] q1_q, q1_d;
  logic [31:0] q2_q, q2_d;
  logic [31:0] q3_q, q3_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;

  // Controller state and registered outputs.
  state_t                state_q, state_d;
  logic [DELAY_BITS-1:0] dly_cnt_q, dly_cnt_d;
  logic [CHAN_BITS-1:0]  chan_idx_q, chan_idx_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  start_out_q, start_out_d;
  logic                  running_q, running_d;
  logic                  frame_sof_q, frame_sof_d;

  // Decoded control fields; use_sync and delay come from the same stage as the edge detect.
  logic                  rise_start;
  logic                  rise_stop;
  logic                  sync_rise;
  logic                  use_sync;
  logic [DELAY_BITS-1:0] delay_val;

  assign rise_start = q2_q[0] & ~q3_q[0];
  assign rise_stop  = q2_q[2] & ~q3_q[2];
  assign sync_rise  = s1_q & ~s2_q;
  assign use_sync   = q2_q[1];
  assign delay_val  = q2_q[16 +: DELAY_BITS];

  // Control-word bits the controller never looks at.
  logic unused_bits;
  assign unused_bits = ^{q2_q[15:3], q3_q[31:3], q3_q[1]};

  // Next-state, counter and output computation.
  always_comb begin
    logic trigger;
    logic enter_run;
    logic advance;

    q1_d        = ctrl.reg_in;
    q2_d        = q1_q;
    q3_d        = q2_q;
    s1_d        = ctrl.sync_in;
    s2_d        = s1_q;

    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    chan_idx_d  = chan_idx_q;
    frame_cnt_d = frame_cnt_q;
    start_out_d = 1'b0;
    running_d   = 1'b0;
    frame_sof_d = 1'b0;

    trigger   = 1'b0;
    enter_run = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start that arrives together with a stop is dropped.
        if (rise_start && !rise_stop) begin
          if (use_sync) state_d = ST_ARMED;
          else          trigger = 1'b1;
        end
      end
      ST_ARMED: begin
        if (rise_stop)      state_d = ST_IDLE;
        else if (sync_rise) trigger = 1'b1;
      end
      ST_DELAY: begin
        // Stop beats an expiring delay.
        if (rise_stop) begin
          state_d   = ST_IDLE;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == DELAY_BITS'(1)) begin
          enter_run = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q - DELAY_BITS'(1);
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (rise_stop) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        // Finish the current frame, then drop back to idle with chan_idx at 0.
        advance = 1'b1;
        if (chan_idx_q == CHAN_LAST) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (trigger) begin
      if (delay_val == '0) begin
        enter_run = 1'b1;
      end else begin
        state_d   = ST_DELAY;
        dly_cnt_d = delay_val;
      end
    end

    if (advance) begin
      if (chan_idx_q == CHAN_LAST) begin
        chan_idx_d  = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        chan_idx_d  = chan_idx_q + CHAN_BITS'(1);
      end
    end

    if (enter_run) begin
      state_d     = ST_RUN;
      dly_cnt_d   = '0;
      chan_idx_d  = '0;
      frame_cnt_d = '0;
      start_out_d = 1'b1;
    end

    running_d   = (state_d == ST_RUN) || (state_d == ST_STOPPING);
    frame_sof_d = running_d && (chan_idx_d == '0);
  end

  // All state and outputs registered; reset clears everything immediately.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= ST_IDLE;
      dly_cnt_q   <= '0;
      chan_idx_q  <= '0;
      frame_cnt_q <= '0;
      start_out_q <= 1'b0;
      running_q   <= 1'b0;
      frame_sof_q <= 1'b0;
    end else begin
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q3_q        <= q3_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      chan_idx_q  <= chan_idx_d;
      frame_cnt_q <= frame_cnt_d;
      start_out_q <= start_out_d;
      running_q   <= running_d;
      frame_sof_q <= frame_sof_d;
    end
  end

  assign ctrl.start_out  = start_out_q;
  assign ctrl.running    = running_q;
  assign ctrl.chan_idx   = chan_idx_q;
  assign ctrl.frame_sof  = frame_sof_q;
  assign ctrl.status_out = {frame_cnt_q, state_q, 4'b0000, 9'(chan_idx_q)};

endmodule

// File: tb/tb_chan_512_start_ctrl.sv
// Directed bench for chan_512_start_ctrl: start/delay/sync/stop sequencing and reset behaviour.
// Latency: expectations are counted in falling edges after the stimulus edge.
// Backpressure: not applicable; inputs driven and outputs sampled on the falling edge.
module tb_chan_512_start_ctrl;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_starts;

  chan_512_start_ctrl_if #(.CHAN_BITS(9)) ctrl_if ();

  chan_512_start_ctrl #(
    .NCHAN      (512),
    .CHAN_BITS  (9),
    .DELAY_BITS (16)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .ctrl     (ctrl_if.slave)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge user_clk);
  endtask

  task automatic count_starts(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge user_clk);
      if (ctrl_if.start_out) cnt++;
    end
  endtask

  function automatic logic [31:0] st();
    return 32'(ctrl_if.status_out[15:13]);
  endfunction

  function automatic logic [31:0] fcnt();
    return 32'(ctrl_if.status_out[31:16]);
  endfunction

  task automatic do_reset();
    user_rst         = 1'b1;
    ctrl_if.reg_in   = 32'h0;
    ctrl_if.sync_in  = 1'b0;
    cyc(2);
    user_rst = 1'b0;
    cyc(3);
  endtask

  initial begin
    ctrl_if.reg_in  = 32'h0;
    ctrl_if.sync_in = 1'b0;

    // Reset values.
    cyc(2);
    chk("rst_status",  ctrl_if.status_out, 32'h0);
    chk("rst_start",   32'(ctrl_if.start_out), 32'h0);
    chk("rst_running", 32'(ctrl_if.running), 32'h0);
    chk("rst_chan",    32'(ctrl_if.chan_idx), 32'h0);
    chk("rst_sof",     32'(ctrl_if.frame_sof), 32'h0);
    user_rst = 1'b0;
    count_starts(5, n_starts);
    chk("rel_no_start", 32'(n_starts), 32'h0);

    // Plain start, D=0, then frame counting, ignored restart, and stop.
    ctrl_if.reg_in = 32'h1;                       // N0
    cyc(1); chk("a_n1_start", 32'(ctrl_if.start_out), 32'h0);
    cyc(1); chk("a_n2_start", 32'(ctrl_if.start_out), 32'h0);
    cyc(1);                                       // N3
    chk("a_n3_start", 32'(ctrl_if.start_out), 32'h1);
    chk("a_n3_run",   32'(ctrl_if.running), 32'h1);
    chk("a_n3_chan",  32'(ctrl_if.chan_idx), 32'h0);
    chk("a_n3_sof",   32'(ctrl_if.frame_sof), 32'h1);
    chk("a_n3_state", st(), 32'd3);
    cyc(1);                                       // N4
    chk("a_n4_start", 32'(ctrl_if.start_out), 32'h0);
    chk("a_n4_chan",  32'(ctrl_if.chan_idx), 32'd1);
    chk("a_n4_sof",   32'(ctrl_if.frame_sof), 32'h0);
    cyc(510);                                     // N514
    chk("a_last_chan", 32'(ctrl_if.chan_idx), 32'd511);
    chk("a_last_sof",  32'(ctrl_if.frame_sof), 32'h0);
    cyc(1);                                       // N515
    chk("a_wrap_chan",  32'(ctrl_if.chan_idx), 32'd0);
    chk("a_wrap_sof",   32'(ctrl_if.frame_sof), 32'h1);
    chk("a_wrap_frame", fcnt(), 32'd1);
    chk("a_wrap_start", 32'(ctrl_if.start_out), 32'h0);
    ctrl_if.reg_in = 32'h0;
    cyc(4);                                       // N519
    ctrl_if.reg_in = 32'h1;
    count_starts(6, n_starts);                    // N525
    chk("a_restart_ignored", 32'(n_starts), 32'h0);
    chk("a_restart_state",   st(), 32'd3);
    chk("a_restart_chan",    32'(ctrl_if.chan_idx), 32'd10);
    cyc(1114);                                    // N1639: frame 3, chan 100
    chk("a_pre_stop_chan",  32'(ctrl_if.chan_idx), 32'd100);
    chk("a_pre_stop_frame", fcnt(), 32'd3);
    ctrl_if.reg_in = 32'h4;
    cyc(2);                                       // N1641
    chk("a_stop_n2_state", st(), 32'd3);
    cyc(1);                                       // N1642
    chk("a_stopping_state", st(), 32'd4);
    chk("a_stopping_run",   32'(ctrl_if.running), 32'h1);
    chk("a_stopping_chan",  32'(ctrl_if.chan_idx), 32'd103);
    cyc(408);                                     // N2050
    chk("a_stop_last_chan",  32'(ctrl_if.chan_idx), 32'd511);
    chk("a_stop_last_run",   32'(ctrl_if.running), 32'h1);
    chk("a_stop_last_state", st(), 32'd4);
    cyc(1);                                       // N2051
    chk("a_idle_status", ctrl_if.status_out, 32'h0004_0000);
    chk("a_idle_run",    32'(ctrl_if.running), 32'h0);
    chk("a_idle_sof",    32'(ctrl_if.frame_sof), 32'h0);
    count_starts(5, n_starts);
    chk("a_idle_nostart", 32'(n_starts), 32'h0);
    chk("a_idle_hold",    ctrl_if.status_out, 32'h0004_0000);

    // Programmable delay D=3.
    do_reset();
    ctrl_if.reg_in = 32'h0003_0001;               // N0
    cyc(3);
    chk("b_n3_state", st(), 32'd2);
    chk("b_n3_start", 32'(ctrl_if.start_out), 32'h0);
    cyc(2);
    chk("b_n5_state", st(), 32'd2);
    chk("b_n5_start", 32'(ctrl_if.start_out), 32'h0);
    cyc(1);
    chk("b_n6_start", 32'(ctrl_if.start_out), 32'h1);
    chk("b_n6_state", st(), 32'd3);
    chk("b_n6_sof",   32'(ctrl_if.frame_sof), 32'h1);
    cyc(1);
    chk("b_n7_start", 32'(ctrl_if.start_out), 32'h0);

    // Stop arriving on the same cycle the delay expires wins.
    do_reset();
    ctrl_if.reg_in = 32'h0002_0001;               // N0, D=2
    cyc(2);
    ctrl_if.reg_in = 32'h0002_0005;               // N2
    cyc(1); chk("b2_n3_state", st(), 32'd2);
    cyc(1); chk("b2_n4_state", st(), 32'd2);
    cyc(1); chk("b2_n5_state", st(), 32'd0);
    count_starts(6, n_starts);
    chk("b2_no_start", 32'(n_starts), 32'h0);

    // External sync start.
    do_reset();
    ctrl_if.reg_in = 32'h3;
    cyc(3);
    chk("c_armed", st(), 32'd1);
    count_starts(1000, n_starts);
    chk("c_armed_nostart", 32'(n_starts), 32'h0);
    chk("c_armed_hold",    st(), 32'd1);
    ctrl_if.sync_in = 1'b1;
    cyc(1);
    chk("c_s1_start", 32'(ctrl_if.start_out), 32'h0);
    chk("c_s1_state", st(), 32'd1);
    ctrl_if.sync_in = 1'b0;
    cyc(1);
    chk("c_s2_start", 32'(ctrl_if.start_out), 32'h1);
    chk("c_s2_state", st(), 32'd3);
    chk("c_s2_run",   32'(ctrl_if.running), 32'h1);
    cyc(10);
    ctrl_if.sync_in = 1'b1;
    cyc(2);
    ctrl_if.sync_in = 1'b0;
    count_starts(6, n_starts);
    chk("c_sync2_ignored", 32'(n_starts), 32'h0);
    chk("c_sync2_state",   st(), 32'd3);

    // Start+stop together from idle, then stop-only while armed.
    do_reset();
    ctrl_if.reg_in = 32'h5;
    count_starts(10, n_starts);
    chk("d_both_nostart", 32'(n_starts), 32'h0);
    chk("d_both_state",   st(), 32'd0);
    ctrl_if.reg_in = 32'h0;
    cyc(3);
    ctrl_if.reg_in = 32'h3;
    cyc(4);
    chk("d_armed", st(), 32'd1);
    ctrl_if.reg_in = 32'h6;
    count_starts(8, n_starts);
    chk("d_disarm_nostart", 32'(n_starts), 32'h0);
    chk("d_disarm_state",   st(), 32'd0);

    // Asynchronous reset in the middle of a delay.
    do_reset();
    ctrl_if.reg_in = 32'h0100_0001;
    cyc(10);
    chk("e_delay_state", st(), 32'd2);
    #2;
    user_rst       = 1'b1;
    ctrl_if.reg_in = 32'h0;
    #1;
    chk("e_drst_status", ctrl_if.status_out, 32'h0);
    chk("e_drst_start",  32'(ctrl_if.start_out), 32'h0);
    chk("e_drst_run",    32'(ctrl_if.running), 32'h0);
    @(negedge user_clk);
    cyc(2);
    user_rst = 1'b0;
    count_starts(10, n_starts);
    chk("e_drel_nostart", 32'(n_starts), 32'h0);
    chk("e_drel_state",   st(), 32'd0);

    // Asynchronous reset in the middle of a run.
    ctrl_if.reg_in = 32'h1;
    cyc(20);
    chk("e_run_before", 32'(ctrl_if.running), 32'h1);
    #2;
    user_rst       = 1'b1;
    ctrl_if.reg_in = 32'h0;
    #1;
    chk("e_rrst_run",    32'(ctrl_if.running), 32'h0);
    chk("e_rrst_chan",   32'(ctrl_if.chan_idx), 32'h0);
    chk("e_rrst_sof",    32'(ctrl_if.frame_sof), 32'h0);
    chk("e_rrst_status", ctrl_if.status_out, 32'h0);
    @(negedge user_clk);
    cyc(1);
    user_rst = 1'b0;
    count_starts(10, n_starts);
    chk("e_rrel_nostart", 32'(n_starts), 32'h0);
    chk("e_rrel_status",  ctrl_if.status_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
